// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core: add/sub/and/or/slt, addi, lw, sw, beq, j.
// Unknown opcodes and functs retire as NOPs; memories are word arrays with combinational reads.

module mips_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_out
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_out <= '0;
    else     pc_out <= pc_d;
  end
endmodule

module mips_imem #(
  parameter int IMEM_WORDS = 64
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int IAW = $clog2(IMEM_WORDS);

  // Loaded from outside the core; never written by the datapath.
  logic [31:0] memory [0:IMEM_WORDS-1] = '{default: 32'h0};

  logic unused_addr;
  assign unused_addr = ^{addr[31:IAW+2], addr[1:0]};

  assign instr = memory[addr[IAW+1:2]];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end
endmodule

module mips_dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int DAW = $clog2(DMEM_WORDS);

  // Byte address bits are used directly as the word index; upper bits wrap away.
  logic [31:0] memory [0:DMEM_WORDS-1];

  logic unused_addr;
  assign unused_addr = ^addr[31:DAW];

  assign rdata = memory[addr[DAW-1:0]];

  always_ff @(posedge clk) begin
    if (we) memory[addr[DAW-1:0]] <= wdata;
  end
endmodule

module mips_cpu #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic clk,
  input  logic reset
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0]        pc_out;
  logic [31:0]        pc_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        instr;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic [31:0]        dmem_rdata;
  logic [31:0]        eff_addr;
  logic signed [31:0] imm_sext;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [25:0] target;

  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        mem_we;

  function automatic logic [31:0] alu_rtype(input logic [5:0] fn,
                                            input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    logic [31:0] res;
    res = '0;
    case (fn)
      FN_ADD:  res = a + b;
      FN_SUB:  res = a - b;
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_SLT:  res = (a < b) ? 32'd1 : 32'd0;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic rtype_defined(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign target   = instr[25:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4 = pc_out + 32'd4;
  assign eff_addr = rs_val + $unsigned(imm_sext);

  mips_pc pc_inst (
    .clk    (clk),
    .rst    (reset),
    .pc_d   (pc_d),
    .pc_out (pc_out)
  );

  mips_imem #(.IMEM_WORDS(IMEM_WORDS)) instruction_memory_inst (
    .addr  (pc_out),
    .instr (instr)
  );

  mips_regfile register_file_inst (
    .clk (clk),
    .rst (reset),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_val),
    .rd2 (rt_val),
    .we  (reg_we),
    .wa  (reg_wa),
    .wd  (reg_wd)
  );

  // Stores are held off during reset so an aborted sw leaves memory untouched.
  mips_dmem #(.DMEM_WORDS(DMEM_WORDS)) data_memory_inst (
    .clk   (clk),
    .we    (mem_we && !reset),
    .addr  (eff_addr),
    .wdata (rt_val),
    .rdata (dmem_rdata)
  );

  always_comb begin
    pc_d   = pc_plus4;
    reg_we = 1'b0;
    reg_wa = rd;
    reg_wd = '0;
    mem_we = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = rtype_defined(funct);
        reg_wd = alu_rtype(funct, $signed(rs_val), $signed(rt_val));
      end
      OP_ADDI: begin
        reg_we = 1'b1;
        reg_wa = rt;
        reg_wd = eff_addr;
      end
      OP_LW: begin
        reg_we = 1'b1;
        reg_wa = rt;
        reg_wd = dmem_rdata;
      end
      OP_SW: begin
        mem_we = 1'b1;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      end
      OP_J: begin
        pc_d = {pc_plus4[31:28], target, 2'b00};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: one-instruction vectors from a table plus short
// hand-written sequences for back-to-back dependencies and asynchronous reset.

module tb_mips_cpu;
  logic clk;
  logic reset;

  int checks;
  int errors;

  mips_cpu #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    int          w1_idx;
    logic [31:0] w1_val;
    int          w2_idx;
    logic [31:0] w2_val;
    int          d_idx;
    logic [31:0] d_val;
    logic [31:0] exp_pc;
    int          chk_reg;
    logic [31:0] exp_reg;
    int          chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 64; k++) dut.instruction_memory_inst.memory[k] = 32'h0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    pulse_reset();
    clear_imem();
    dut.instruction_memory_inst.memory[v.pc[7:2]] = v.instr;
    dut.register_file_inst.regs[v.w1_idx] = v.w1_val;
    dut.register_file_inst.regs[v.w2_idx] = v.w2_val;
    dut.data_memory_inst.memory[v.d_idx] = v.d_val;
    repeat (int'(v.pc[7:2]) + 1) @(posedge clk);
    #1;
    check({v.name, ".pc"},  dut.pc_inst.pc_out, v.exp_pc);
    check({v.name, ".reg"}, dut.register_file_inst.regs[v.chk_reg], v.exp_reg);
    check({v.name, ".mem"}, dut.data_memory_inst.memory[v.chk_mem], v.exp_mem);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //          name       pc     instr         w1           w2                  dmem        exp_pc  reg check          mem check
    vecs[0]  = '{"add",     0,  32'h00622020, 2, 32'd2,       3, 32'd3,           5, 32'd0,   4,  4, 32'd5,          5, 32'd0};
    vecs[1]  = '{"sub",     4,  32'h00853022, 4, 32'd5,       5, 32'd3,           5, 32'd0,   8,  6, 32'd2,          5, 32'd0};
    vecs[2]  = '{"lw",      0,  32'h8C040004, 20, 32'd0,      21, 32'd0,          4, 32'd10,  4,  4, 32'd10,         4, 32'd10};
    vecs[3]  = '{"sw",      0,  32'hAC02000A, 2, 32'd20,      21, 32'd0,          10, 32'd0,  4,  2, 32'd20,         10, 32'd20};
    vecs[4]  = '{"beq_t",   16, 32'h10220004, 1, 32'd5,       2, 32'd5,           5, 32'd0,   36, 2, 32'd5,          5, 32'd0};
    vecs[5]  = '{"beq_nt",  16, 32'h10220004, 1, 32'd5,       2, 32'd6,           5, 32'd0,   20, 2, 32'd6,          5, 32'd0};
    vecs[6]  = '{"add_r0",  0,  32'h00620020, 2, 32'd2,       3, 32'd3,           5, 32'd0,   4,  0, 32'd0,          5, 32'd0};
    vecs[7]  = '{"and",     0,  32'h00223824, 1, 32'hF0F000FF, 2, 32'h0FF00F0F,   5, 32'd0,   4,  7, 32'h00F0000F,   5, 32'd0};
    vecs[8]  = '{"or",      0,  32'h00223825, 1, 32'hF0F000FF, 2, 32'h0FF00F0F,   5, 32'd0,   4,  7, 32'hFFF00FFF,   5, 32'd0};
    vecs[9]  = '{"slt_neg", 0,  32'h0022402A, 1, 32'hFFFFFFFF, 2, 32'd1,          5, 32'd0,   4,  8, 32'd1,          5, 32'd0};
    vecs[10] = '{"slt_pos", 0,  32'h0022402A, 1, 32'd1,       2, 32'hFFFFFFFF,    5, 32'd0,   4,  8, 32'd0,          5, 32'd0};
    vecs[11] = '{"addi_m1", 0,  32'h2029FFFF, 1, 32'd0,       2, 32'd0,           5, 32'd0,   4,  9, 32'hFFFFFFFF,   5, 32'd0};
    vecs[12] = '{"add_ovf", 0,  32'h00622020, 2, 32'd1,       3, 32'h7FFFFFFF,    5, 32'd0,   4,  4, 32'h80000000,   5, 32'd0};
    vecs[13] = '{"j",       0,  32'h08000010, 1, 32'd0,       2, 32'd0,           5, 32'd0,   32'h40, 1, 32'd0,     5, 32'd0};
    vecs[14] = '{"bad_op",  0,  32'hFC853022, 4, 32'd5,       5, 32'd3,           6, 32'd9,   4,  6, 32'd0,          6, 32'd9};
    vecs[15] = '{"bad_fn",  0,  32'h00853021, 4, 32'd5,       5, 32'd3,           6, 32'd9,   4,  6, 32'd0,          6, 32'd9};
    vecs[16] = '{"lw_wrap", 0,  32'h8C040044, 20, 32'd0,      21, 32'd0,          4, 32'd10,  4,  4, 32'd10,         4, 32'd10};
    vecs[17] = '{"sw_neg",  0,  32'hAC22FFFE, 1, 32'd12,      2, 32'd77,          10, 32'd0,  4,  1, 32'd12,         10, 32'd77};

    // Reset state before any clock edge is taken out of reset.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    check("reset.pc", dut.pc_inst.pc_out, 32'h0);
    check("reset.r31", dut.register_file_inst.regs[31], 32'h0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Dependent sequence: addi, add reading its own destination, sw, lw.
    pulse_reset();
    clear_imem();
    dut.instruction_memory_inst.memory[0] = 32'h20010007; // addi $1,$0,7
    dut.instruction_memory_inst.memory[1] = 32'h00210820; // add  $1,$1,$1
    dut.instruction_memory_inst.memory[2] = 32'hAC010003; // sw   $1,3($0)
    dut.instruction_memory_inst.memory[3] = 32'h8C020003; // lw   $2,3($0)
    dut.data_memory_inst.memory[3] = 32'h0;
    @(posedge clk); #1;
    check("seq.addi", dut.register_file_inst.regs[1], 32'd7);
    @(posedge clk); #1;
    check("seq.add_self", dut.register_file_inst.regs[1], 32'd14);
    @(posedge clk); #1;
    check("seq.sw", dut.data_memory_inst.memory[3], 32'd14);
    @(posedge clk); #1;
    check("seq.lw", dut.register_file_inst.regs[2], 32'd14);
    check("seq.pc", dut.pc_inst.pc_out, 32'd16);

    // Asynchronous reset mid-run, then clocks while held: no stores, memories kept.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst.pc", dut.pc_inst.pc_out, 32'h0);
    check("arst.r1", dut.register_file_inst.regs[1], 32'h0);
    check("arst.r2", dut.register_file_inst.regs[2], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("arst.hold_pc", dut.pc_inst.pc_out, 32'h0);
    check("arst.dmem", dut.data_memory_inst.memory[3], 32'd14);
    check("arst.imem", dut.instruction_memory_inst.memory[2], 32'hAC010003);

    // First edge after release executes address 0.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post.addi", dut.register_file_inst.regs[1], 32'd7);
    check("post.pc", dut.pc_inst.pc_out, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_cpu.md
MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 IMEM_WORDS, 64, instruction memory depth in 32-bit words.
REQ-002 DMEM_WORDS, 64, data memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 No other ports; observability is through the hierarchical state in REQ-006.
REQ-006 The block SHALL expose these internal instances and names:
- instruction_memory_inst.memory[0:IMEM_WORDS-1], 32-bit words.
- register_file_inst.regs[0:31], 32-bit registers.
- data_memory_inst.memory[0:DMEM_WORDS-1], 32-bit words.
- pc_inst.pc_out, 32-bit program counter.

Function
REQ-007 Single-cycle datapath: each instruction is fetched, decoded, executed and committed within one clk period; the commit happens on the rising edge that ends the period.
REQ-008 Fetch:
- instruction = instruction_memory_inst.memory[pc_out[log2(IMEM_WORDS)+1:2]].
- Read is combinational.
- Instruction memory is initialised to all zeros; word 0x00000000 executes as a NOP.
REQ-009 Next PC selection:
- Default: pc_out+4, modulo 2^32.
- beq taken: pc_out+4+(sign_extend(imm16)<<2).
- j: {pc_plus4[31:28], target26, 2'b00}.
REQ-010 The following R-type instructions (opcode 0x00) SHALL write rd:
- funct 0x20 add: rs+rt.
- funct 0x22 sub: rs-rt.
- funct 0x24 and.
- funct 0x25 or.
- funct 0x2A slt: signed compare; result is 1 or 0.
REQ-011 Arithmetic is 32-bit two's complement; overflow wraps and raises no exception.
REQ-012 I-type instructions:
- lw (0x23): rt <= dmem[rs+sext(imm)].
- sw (0x2B): dmem[rs+sext(imm)] <= rt.
- addi (0x08): rt <= rs+sext(imm).
- beq (0x04): taken when rs == rt.
- j (0x02).
REQ-013 Data memory addressing:
- Index = low log2(DMEM_WORDS) bits of the effective address; no divide by 4.
- Example: effective address 10 accesses memory[10].
- Out-of-range addresses wrap by truncation.
REQ-014 Data memory read is combinational; writes are synchronous on the rising edge, only for sw.
REQ-015 Register file:
- Two combinational read ports and one synchronous write port.
- Writes to register 0 are discarded.
- regs[0] always reads 0.
REQ-016 Any undefined opcode or funct SHALL behave as a NOP: no register write, no memory write, PC advances by 4.
REQ-017 A read of a register being written in the same cycle returns the old value; the new value is visible the next cycle.
REQ-018 Hierarchical writes made by a testbench to memories or registers between clock edges SHALL be honoured on the next rising edge.

Reset
REQ-019 While reset=1, pc_out is 0 immediately, independent of clk.
REQ-020 While reset=1, all regs[1:31] are 0.
REQ-021 While reset=1, no memory writes occur.
REQ-022 Instruction memory and data memory contents are not altered by reset.
REQ-023 After reset is deasserted, the first rising edge executes the instruction at address 0.
REQ-024 Asserting reset mid-execution aborts the current instruction; no partial register or memory write occurs.

Verification
REQ-025 Scenario: regs[2]=2, regs[3]=3, imem[0]=add $4,$3,$2 (0x00622020); release reset; one edge -> regs[4]=5, pc_out=4.
REQ-026 Scenario: regs[4]=5, regs[5]=3, imem[1]=sub $6,$4,$5 (0x00853022) -> regs[6]=2 after its edge.
REQ-027 Scenario: dmem[4]=10, lw $4,4($0) (0x8C040004) -> regs[4]=10.
REQ-028 Scenario: regs[2]=20, sw $2,10($0) (0xAC02000A) -> dmem[10]=20, no register changes.
REQ-029 Scenario: regs[1]=regs[2]=5, beq $1,$2,+4 (0x10220004) at pc 16 -> pc_out=36.
- Same instruction with regs[2]=6 -> pc_out=20.
REQ-030 Scenario: add $0,$3,$2 -> regs[0] stays 0.
- Assert reset mid-run -> pc_out=0 and regs cleared without a clock edge.
